// File: rtl/seg7_scan_decoder_if.sv
// Seven-segment scan bus: the multiplexed display drive going into the
// decoder, plus the decoded frame and status coming back out.
// The display driver side is the master, the decoder is the slave.
interface seg7_scan_if;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [3:0] an_in;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic [3:0] dp_out;
  logic       frame_valid;
  logic       bad_glyph;
  logic       scan_timeout;

  modport master (
    output seg_in, dp_in, an_in,
    input  digit3, digit2, digit1, digit0, dp_out,
    input  frame_valid, bad_glyph, scan_timeout
  );

  modport slave (
    input  seg_in, dp_in, an_in,
    output digit3, digit2, digit1, digit0, dp_out,
    output frame_valid, bad_glyph, scan_timeout
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed, active-low display
// drive, debounces each digit slot, decodes the glyph back to a hex nibble
// and publishes a complete four-digit frame once every slot has been seen.
// Optional feature macro: SEG7_DEC_DP_CAPTURE_EN (capture decimal points).
module seg7_scan_decoder #(
  parameter int STABLE_CNT     = 16,
  parameter int TIMEOUT_CYCLES = 4194304
) (
  input logic       clk,
  input logic       reset,
  seg7_scan_if.slave bus
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      StableMax  = 8'(STABLE_CNT);
  localparam logic [TW-1:0]   TimeoutMax = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    work_q [4];
  logic [3:0]    work_d [4];
  logic [3:0]    seen_q, seen_d;
  logic [3:0]    digit_q [4];
  logic [3:0]    digit_d [4];
  logic [TW-1:0] tmo_q, tmo_d;
  logic          scan_timeout_q, scan_timeout_d;
  logic          frame_valid_q, frame_valid_d;
  logic          bad_glyph_q, bad_glyph_d;

`ifdef SEG7_DEC_DP_CAPTURE_EN
  logic          dp_q, dp_d;
  logic [3:0]    dpw_q, dpw_d;
  logic [3:0]    dp_out_q, dp_out_d;
`else
  logic          dp_unused;
  assign dp_unused = bus.dp_in;
`endif

  logic          an_valid;
  logic [1:0]    an_idx;
  logic          same_sample;
  logic          glyph_ok;
  logic [3:0]    glyph_val;
  logic          load;
  logic          accept;
  logic          legal_accept;

  // A sample is only meaningful when exactly one anode is driven low.
  always_comb begin
    an_valid = 1'b0;
    an_idx   = 2'd0;
    case (bus.an_in)
      4'b1110: begin an_valid = 1'b1; an_idx = 2'd0; end
      4'b1101: begin an_valid = 1'b1; an_idx = 2'd1; end
      4'b1011: begin an_valid = 1'b1; an_idx = 2'd2; end
      4'b0111: begin an_valid = 1'b1; an_idx = 2'd3; end
      default: begin an_valid = 1'b0; an_idx = 2'd0; end
    endcase
  end

`ifdef SEG7_DEC_DP_CAPTURE_EN
  assign same_sample = (bus.an_in == an_q) && (bus.seg_in == seg_q) && (bus.dp_in == dp_q);
`else
  assign same_sample = (bus.an_in == an_q) && (bus.seg_in == seg_q);
`endif

  // Map the active-low segment pattern back to the nibble it displays.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (bus.seg_in)
      7'h40:   glyph_val = 4'h0;
      7'h79:   glyph_val = 4'h1;
      7'h24:   glyph_val = 4'h2;
      7'h30:   glyph_val = 4'h3;
      7'h19:   glyph_val = 4'h4;
      7'h12:   glyph_val = 4'h5;
      7'h02:   glyph_val = 4'h6;
      7'h78:   glyph_val = 4'h7;
      7'h00:   glyph_val = 4'h8;
      7'h10:   glyph_val = 4'h9;
      7'h08:   glyph_val = 4'hA;
      7'h03:   glyph_val = 4'hB;
      7'h46:   glyph_val = 4'hC;
      7'h21:   glyph_val = 4'hD;
      7'h06:   glyph_val = 4'hE;
      7'h0E:   glyph_val = 4'hF;
      default: glyph_ok  = 1'b0;
    endcase
  end

  // Next-state logic: debounce FSM, frame assembly and scan-loss watchdog.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    an_d           = an_q;
    seg_d          = seg_q;
    work_d         = work_q;
    seen_d         = seen_q;
    digit_d        = digit_q;
    tmo_d          = tmo_q;
    scan_timeout_d = scan_timeout_q;
    frame_valid_d  = 1'b0;
    bad_glyph_d    = 1'b0;
    load           = 1'b0;
    accept         = 1'b0;
    legal_accept   = 1'b0;
`ifdef SEG7_DEC_DP_CAPTURE_EN
    dp_d           = dp_q;
    dpw_d          = dpw_q;
    dp_out_d       = dp_out_q;
`endif

    case (state_q)
      IDLE: begin
        if (an_valid) load = 1'b1;
      end
      SETTLE: begin
        if (!an_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (same_sample) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == StableMax) begin
            accept  = 1'b1;
            state_d = HELD;
          end
        end else begin
          load = 1'b1;
        end
      end
      HELD: begin
        if (!an_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same_sample) begin
          load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new pattern restarts the stability run from its first sample.
    if (load) begin
      an_d    = bus.an_in;
      seg_d   = bus.seg_in;
      cnt_d   = 8'd1;
      state_d = SETTLE;
`ifdef SEG7_DEC_DP_CAPTURE_EN
      dp_d    = bus.dp_in;
`endif
    end

    legal_accept = accept && glyph_ok;
    bad_glyph_d  = accept && !glyph_ok;

    if (legal_accept) begin
      work_d[an_idx] = glyph_val;
      seen_d[an_idx] = 1'b1;
`ifdef SEG7_DEC_DP_CAPTURE_EN
      dpw_d[an_idx]  = ~bus.dp_in;
`endif
      // The accept that completes the set publishes the whole frame at once.
      if (seen_d == 4'hF) begin
        digit_d       = work_d;
        frame_valid_d = 1'b1;
        seen_d        = 4'h0;
`ifdef SEG7_DEC_DP_CAPTURE_EN
        dp_out_d      = dpw_d;
`endif
      end
      tmo_d          = '0;
      scan_timeout_d = 1'b0;
    end else begin
      tmo_d = (tmo_q == TimeoutMax) ? tmo_q : tmo_q + TW'(1);
      // An accept on the same edge wins; the loss is then flagged a cycle later.
      if (!accept && !scan_timeout_q && (tmo_d == TimeoutMax)) begin
        scan_timeout_d = 1'b1;
        seen_d         = 4'h0;
      end
    end
  end

  // All state and every output is registered here; reset dominates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      an_q           <= 4'hF;
      seg_q          <= 7'h7F;
      seen_q         <= 4'h0;
      tmo_q          <= '0;
      scan_timeout_q <= 1'b0;
      frame_valid_q  <= 1'b0;
      bad_glyph_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        work_q[i]  <= 4'h0;
        digit_q[i] <= 4'h0;
      end
`ifdef SEG7_DEC_DP_CAPTURE_EN
      dp_q           <= 1'b1;
      dpw_q          <= 4'h0;
      dp_out_q       <= 4'h0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      seen_q         <= seen_d;
      tmo_q          <= tmo_d;
      scan_timeout_q <= scan_timeout_d;
      frame_valid_q  <= frame_valid_d;
      bad_glyph_q    <= bad_glyph_d;
      for (int i = 0; i < 4; i++) begin
        work_q[i]  <= work_d[i];
        digit_q[i] <= digit_d[i];
      end
`ifdef SEG7_DEC_DP_CAPTURE_EN
      dp_q           <= dp_d;
      dpw_q          <= dpw_d;
      dp_out_q       <= dp_out_d;
`endif
    end
  end

  assign bus.digit3       = digit_q[3];
  assign bus.digit2       = digit_q[2];
  assign bus.digit1       = digit_q[1];
  assign bus.digit0       = digit_q[0];
  assign bus.frame_valid  = frame_valid_q;
  assign bus.bad_glyph    = bad_glyph_q;
  assign bus.scan_timeout = scan_timeout_q;
`ifdef SEG7_DEC_DP_CAPTURE_EN
  assign bus.dp_out       = dp_out_q;
`else
  assign bus.dp_out       = 4'h0;
`endif

endmodule
